sensor_snapshot_buffer: RTL and testbench
=========================================

Name: sensor_snapshot_buffer

Overview:
- Sits directly downstream of the per-context sensor interface stage. Consumes its per-cycle sensor address and read-enable and returns the sensor value to the CGRA datapath.
- Sensor values arrive from the external sensor bus over a valid/ready write port into a staging bank.
- A SYNC pulse atomically swaps the staging and active banks, so one CGRA run always reads a consistent snapshot.
- After each swap, a copy engine refreshes the new staging bank from the active bank so that unwritten sensors keep their latest values.

Parameters:
- SENSOR_COUNT, 16, number of sensors (bank depth), 2..2^SENSOR_ID_WIDTH.
- SENSOR_ID_WIDTH, 4, width of sensor address/ID.
- DATA_WIDTH, 32, sensor value width.

Ports:
- CGRA_CLK_I  in  1  clock; all logic rising-edge.
- RST_I  in  1  asynchronous, active-high reset.
- EN_I  in  1  CGRA run enable; gates the read side only.
- SENSOR_ADDR_I  in  SENSOR_ID_WIDTH  sensor to read (from context stage).
- SENSOR_READ_EN_I  in  1  read request (from context stage).
- SENSOR_DATA_O  out  DATA_WIDTH  read data.
- SENSOR_DATA_VALID_O  out  1  one-cycle pulse: SENSOR_DATA_O is new.
- RD_ERR_O  out  1  one-cycle pulse: out-of-range read.
- SENSOR_WR_VALID_I  in  1  sensor bus write valid.
- SENSOR_WR_READY_O  out  1  write port ready.
- SENSOR_WR_ID_I  in  SENSOR_ID_WIDTH  sensor being written.
- SENSOR_WR_DATA_I  in  DATA_WIDTH  value written.
- WR_ERR_O  out  1  sticky: an out-of-range write was dropped.
- SYNC_I  in  1  snapshot request pulse.
- SYNC_BUSY_O  out  1  high while COPY runs or a SYNC is pending.
- FRESH_O  out  SENSOR_COUNT  bit i = sensor i was written in the interval captured by the current active snapshot.

Behaviour:
- Storage: two register banks (bank0, bank1) of SENSOR_COUNT x DATA_WIDTH, a bank-select bit `act` (active bank), and a staging-fresh vector `sfresh`.
- Reset (async, any state, including mid-COPY):
  - banks, SENSOR_DATA_O, SENSOR_DATA_VALID_O, RD_ERR_O, WR_ERR_O, FRESH_O, sfresh, `act`, pending flag and copy index all reset to 0;
  - FSM enters IDLE;
  - SENSOR_WR_READY_O = 0 during reset, 1 in IDLE afterwards.
- Read side:
  - When EN_I & SENSOR_READ_EN_I at edge N:
    - addr < SENSOR_COUNT: SENSOR_DATA_O <= active[addr] and VALID = 1 after edge N (latency 1).
    - addr out of range: SENSOR_DATA_O <= 0, VALID = 1, RD_ERR_O = 1.
  - Otherwise VALID and RD_ERR are 0 and SENSOR_DATA_O holds.
  - EN_I has no effect on the write side or the FSM.
  - A read at the same edge as a swap returns the pre-swap active bank.
- Write side:
  - Transfer occurs when VALID & READY; READY = (state == IDLE).
  - In range: staging[id] <= data and sfresh[id] <= 1.
  - ID >= SENSOR_COUNT: write dropped, WR_ERR_O <= 1 (sticky until reset). The transfer still completes.
- FSM states: IDLE, COPY.
  - IDLE, swap condition = SYNC_I | pending. On swap:
    - `act` <= ~act;
    - FRESH_O <= sfresh, with the bit of a same-edge in-range write forced to 1;
    - sfresh <= 0; pending <= 0; index <= 0; state -> COPY.
    - A write accepted on the swap edge lands in the old staging bank, so it is included in the new snapshot.
  - COPY, one element per cycle:
    - new_staging[index] <= new_active[index]; index++.
    - After the edge copying index SENSOR_COUNT-1, state -> IDLE.
    - COPY lasts exactly SENSOR_COUNT cycles; READY = 0 throughout.
  - SYNC_I in COPY sets pending (multiple pulses collapse to one). The swap executes on the first IDLE cycle after COPY.
  - SYNC_BUSY_O = (state == COPY) | pending, registered.
- Widths: copy index is SENSOR_ID_WIDTH bits; range compares are unsigned.

Test Plan:
- Reset, then write id 3 = 0xDEADBEEF, then SYNC, wait 16 cycles, read addr 3 with EN_I = 1 -> SENSOR_DATA_O = 0xDEADBEEF one cycle later, VALID pulse, FRESH_O = 0x0008.
- Write id 5 = 0x11 then SYNC; next snapshot: write only id 2 = 0x22 then SYNC, wait for copy -> read 5 = 0x11 (copied forward), read 2 = 0x22, FRESH_O = 0x0004.
- Write id 7 = 0xAA on the same edge as SYNC -> after swap read 7 = 0xAA, FRESH_O bit 7 = 1.
- SYNC, then SYNC again at COPY cycle 4 -> SYNC_BUSY_O stays high; second swap occurs exactly one cycle after COPY ends; READY low for 32 total cycles minus 1 IDLE gap.
- Read addr 15 with SENSOR_COUNT = 12 -> data 0, VALID = 1, RD_ERR_O = 1 for one cycle. Write id 13 -> WR_ERR_O = 1 and remains 1; banks unchanged.
- Assert RST_I asynchronously at COPY cycle 6 -> all outputs 0 immediately; after release READY = 1 and all reads return 0.

Source files
------------

// File: rtl/sensor_snapshot_buffer_if.sv
// Sensor snapshot buffer bus: context-stage read port, sensor-bus write port,
// snapshot control and status. The slave modport is the buffer side.
interface sensor_snapshot_buffer_if #(
    parameter int SENSOR_COUNT    = 16,
    parameter int SENSOR_ID_WIDTH = 4,
    parameter int DATA_WIDTH      = 32
);
    logic                       EN_I;
    logic [SENSOR_ID_WIDTH-1:0] SENSOR_ADDR_I;
    logic                       SENSOR_READ_EN_I;
    logic [DATA_WIDTH-1:0]      SENSOR_DATA_O;
    logic                       SENSOR_DATA_VALID_O;
    logic                       RD_ERR_O;
    logic                       SENSOR_WR_VALID_I;
    logic                       SENSOR_WR_READY_O;
    logic [SENSOR_ID_WIDTH-1:0] SENSOR_WR_ID_I;
    logic [DATA_WIDTH-1:0]      SENSOR_WR_DATA_I;
    logic                       WR_ERR_O;
    logic                       SYNC_I;
    logic                       SYNC_BUSY_O;
    logic [SENSOR_COUNT-1:0]    FRESH_O;

    modport master (
        output EN_I, SENSOR_ADDR_I, SENSOR_READ_EN_I,
        output SENSOR_WR_VALID_I, SENSOR_WR_ID_I, SENSOR_WR_DATA_I, SYNC_I,
        input  SENSOR_DATA_O, SENSOR_DATA_VALID_O, RD_ERR_O,
        input  SENSOR_WR_READY_O, WR_ERR_O, SYNC_BUSY_O, FRESH_O
    );

    modport slave (
        input  EN_I, SENSOR_ADDR_I, SENSOR_READ_EN_I,
        input  SENSOR_WR_VALID_I, SENSOR_WR_ID_I, SENSOR_WR_DATA_I, SYNC_I,
        output SENSOR_DATA_O, SENSOR_DATA_VALID_O, RD_ERR_O,
        output SENSOR_WR_READY_O, WR_ERR_O, SYNC_BUSY_O, FRESH_O
    );
endinterface

// File: rtl/sensor_snapshot_buffer.sv
// Double-banked sensor snapshot buffer: sensor bus writes into a staging bank,
// SYNC swaps banks atomically, then a copy engine refreshes the new staging bank.
module sensor_snapshot_buffer #(
    parameter int SENSOR_COUNT    = 16,
    parameter int SENSOR_ID_WIDTH = 4,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                   CGRA_CLK_I,
    input  logic                   RST_I,
    sensor_snapshot_buffer_if.slave BUS
);

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } state_t;

    localparam logic [SENSOR_ID_WIDTH-1:0] LAST_IDX = SENSOR_ID_WIDTH'(SENSOR_COUNT - 1);

    state_t                     state_q, state_d;
    logic                       act_q;
    logic                       pending_q, pending_d;
    logic                       busy_q;
    logic                       wr_err_q;
    logic                       rd_valid_q, rd_err_q;
    logic [DATA_WIDTH-1:0]      rd_data_q;
    logic [SENSOR_ID_WIDTH-1:0] idx_q;
    logic [SENSOR_COUNT-1:0]    sfresh_q, fresh_q, fresh_d;
    logic [DATA_WIDTH-1:0]      bank_q [2][SENSOR_COUNT];

    logic wr_ready, swap, copy_en;
    logic rd_req, rd_in_range;
    logic wr_fire, wr_in_range;

    assign rd_req      = BUS.EN_I & BUS.SENSOR_READ_EN_I;
    assign rd_in_range = 32'(BUS.SENSOR_ADDR_I) < SENSOR_COUNT;
    assign wr_fire     = BUS.SENSOR_WR_VALID_I & wr_ready;
    assign wr_in_range = 32'(BUS.SENSOR_WR_ID_I) < SENSOR_COUNT;

    always_ff @(posedge CGRA_CLK_I or posedge RST_I) begin
        if (RST_I) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (BUS.SYNC_I | pending_q) state_d = COPY;
            COPY: if (idx_q == LAST_IDX)      state_d = IDLE;
        endcase
    end

    // READY is forced low while reset is asserted, even though the FSM sits in IDLE.
    always_comb begin
        wr_ready = (state_q == IDLE) & ~RST_I;
        swap     = (state_q == IDLE) & (BUS.SYNC_I | pending_q);
        copy_en  = (state_q == COPY);
    end

    always_comb begin
        pending_d = pending_q;
        if (swap)                       pending_d = 1'b0;
        else if (copy_en & BUS.SYNC_I)  pending_d = 1'b1;
        fresh_d = sfresh_q;
        if (wr_fire & wr_in_range) fresh_d[BUS.SENSOR_WR_ID_I] = 1'b1;
    end

    always_ff @(posedge CGRA_CLK_I or posedge RST_I) begin
        if (RST_I) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned i = 0; i < SENSOR_COUNT; i++) begin
                    bank_q[b][i] <= '0;
                end
            end
            act_q      <= 1'b0;
            pending_q  <= 1'b0;
            busy_q     <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
            idx_q      <= '0;
            sfresh_q   <= '0;
            fresh_q    <= '0;
        end else begin
            pending_q  <= pending_d;
            busy_q     <= (state_d == COPY) | pending_d;
            rd_valid_q <= rd_req;
            rd_err_q   <= rd_req & ~rd_in_range;
            // Reads see act_q before any same-edge swap, i.e. the pre-swap snapshot.
            if (rd_req) rd_data_q <= rd_in_range ? bank_q[act_q][BUS.SENSOR_ADDR_I] : '0;

            if (wr_fire) begin
                if (wr_in_range) bank_q[~act_q][BUS.SENSOR_WR_ID_I] <= BUS.SENSOR_WR_DATA_I;
                else             wr_err_q <= 1'b1;
            end

            if (swap) begin
                act_q    <= ~act_q;
                fresh_q  <= fresh_d;
                sfresh_q <= '0;
                idx_q    <= '0;
            end else if (wr_fire & wr_in_range) begin
                sfresh_q <= fresh_d;
            end

            if (copy_en) begin
                bank_q[~act_q][idx_q] <= bank_q[act_q][idx_q];
                idx_q                 <= idx_q + SENSOR_ID_WIDTH'(1);
            end
        end
    end

    assign BUS.SENSOR_DATA_O       = rd_data_q;
    assign BUS.SENSOR_DATA_VALID_O = rd_valid_q;
    assign BUS.RD_ERR_O            = rd_err_q;
    assign BUS.SENSOR_WR_READY_O   = wr_ready;
    assign BUS.WR_ERR_O            = wr_err_q;
    assign BUS.SYNC_BUSY_O         = busy_q;
    assign BUS.FRESH_O             = fresh_q;

endmodule

// File: tb/tb_sensor_snapshot_buffer.sv
// Bench for sensor_snapshot_buffer: scenario tasks plus randomized traffic
// checked against a snapshot-level model (staging array copied into active on SYNC).
module tb_sensor_snapshot_buffer;

    localparam int N = 12;
    localparam int W = 4;
    localparam int D = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sensor_snapshot_buffer_if #(.SENSOR_COUNT(N), .SENSOR_ID_WIDTH(W), .DATA_WIDTH(D)) bus ();

    sensor_snapshot_buffer #(.SENSOR_COUNT(N), .SENSOR_ID_WIDTH(W), .DATA_WIDTH(D)) dut (
        .CGRA_CLK_I (clk),
        .RST_I      (rst),
        .BUS        (bus.slave)
    );

    logic [D-1:0] m_act [N];
    logic [D-1:0] m_stg [N];
    logic [N-1:0] m_fresh, m_sfresh;
    logic         m_wr_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.EN_I              = 1'b0;
        bus.SENSOR_ADDR_I     = '0;
        bus.SENSOR_READ_EN_I  = 1'b0;
        bus.SENSOR_WR_VALID_I = 1'b0;
        bus.SENSOR_WR_ID_I    = '0;
        bus.SENSOR_WR_DATA_I  = '0;
        bus.SYNC_I            = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = '0;
            m_stg[i] = '0;
        end
        m_fresh  = '0;
        m_sfresh = '0;
        m_wr_err = 1'b0;
    endtask

    task automatic model_write(input logic [W-1:0] id, input logic [D-1:0] v);
        if (int'(id) < N) begin
            m_stg[id]    = v;
            m_sfresh[id] = 1'b1;
        end else begin
            m_wr_err = 1'b1;
        end
    endtask

    // After the copy completes, staging mirrors the new snapshot, so only act changes.
    task automatic model_swap();
        for (int i = 0; i < N; i++) m_act[i] = m_stg[i];
        m_fresh  = m_sfresh;
        m_sfresh = '0;
    endtask

    task automatic wait_ready(output int lowcnt);
        lowcnt = 0;
        while (bus.SENSOR_WR_READY_O !== 1'b1 && lowcnt < 200) begin
            lowcnt++;
            tick();
        end
        if (lowcnt >= 200) begin
            chk_cnt++;
            $display("FAIL wait_ready: READY still %b after %0d cycles, required 1", bus.SENSOR_WR_READY_O, lowcnt);
        end
    endtask

    task automatic do_write(input logic [W-1:0] id, input logic [D-1:0] v);
        int lc;
        wait_ready(lc);
        bus.SENSOR_WR_VALID_I = 1'b1;
        bus.SENSOR_WR_ID_I    = id;
        bus.SENSOR_WR_DATA_I  = v;
        tick();
        bus.SENSOR_WR_VALID_I = 1'b0;
        model_write(id, v);
        chk_cnt++;
        if (bus.WR_ERR_O !== m_wr_err)
            $display("FAIL write_err id=%0d: got %b, required %b", id, bus.WR_ERR_O, m_wr_err);
        else pass_cnt++;
    endtask

    task automatic do_sync();
        int lc;
        wait_ready(lc);
        bus.SYNC_I = 1'b1;
        tick();
        bus.SYNC_I = 1'b0;
        model_swap();
        chk_cnt++;
        if (bus.SYNC_BUSY_O !== 1'b1) $display("FAIL sync_busy_start: got %b, required 1", bus.SYNC_BUSY_O);
        else pass_cnt++;
        wait_ready(lc);
        chk_cnt++;
        if (lc != N) $display("FAIL copy_len: READY low %0d cycles, required %0d", lc, N);
        else pass_cnt++;
        chk_cnt++;
        if (bus.SYNC_BUSY_O !== 1'b0) $display("FAIL sync_busy_end: got %b, required 0", bus.SYNC_BUSY_O);
        else pass_cnt++;
        chk_cnt++;
        if (bus.FRESH_O !== m_fresh) $display("FAIL fresh: got %h, required %h", bus.FRESH_O, m_fresh);
        else pass_cnt++;
    endtask

    task automatic do_read(input logic [W-1:0] addr);
        logic [D-1:0] exp;
        logic         oor;
        oor = (int'(addr) >= N);
        exp = oor ? '0 : m_act[addr];
        bus.EN_I             = 1'b1;
        bus.SENSOR_READ_EN_I = 1'b1;
        bus.SENSOR_ADDR_I    = addr;
        tick();
        bus.EN_I             = 1'b0;
        bus.SENSOR_READ_EN_I = 1'b0;
        chk_cnt++;
        if (bus.SENSOR_DATA_O !== exp) $display("FAIL read_data a=%0d: got %h, required %h", addr, bus.SENSOR_DATA_O, exp);
        else pass_cnt++;
        chk_cnt++;
        if (bus.SENSOR_DATA_VALID_O !== 1'b1) $display("FAIL read_valid a=%0d: got %b, required 1", addr, bus.SENSOR_DATA_VALID_O);
        else pass_cnt++;
        chk_cnt++;
        if (bus.RD_ERR_O !== oor) $display("FAIL read_err a=%0d: got %b, required %b", addr, bus.RD_ERR_O, oor);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.SENSOR_DATA_VALID_O !== 1'b0 || bus.RD_ERR_O !== 1'b0)
            $display("FAIL read_pulse a=%0d: valid=%b err=%b, required 0/0", addr, bus.SENSOR_DATA_VALID_O, bus.RD_ERR_O);
        else pass_cnt++;
        chk_cnt++;
        if (bus.SENSOR_DATA_O !== exp) $display("FAIL read_hold a=%0d: got %h, required %h", addr, bus.SENSOR_DATA_O, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        tick();
        tick();
        chk_cnt++;
        if (bus.SENSOR_DATA_O !== '0 || bus.SENSOR_DATA_VALID_O !== 1'b0 || bus.RD_ERR_O !== 1'b0 ||
            bus.WR_ERR_O !== 1'b0 || bus.FRESH_O !== '0 || bus.SYNC_BUSY_O !== 1'b0)
            $display("FAIL reset_outputs: data=%h v=%b re=%b we=%b fresh=%h busy=%b, required all 0",
                     bus.SENSOR_DATA_O, bus.SENSOR_DATA_VALID_O, bus.RD_ERR_O, bus.WR_ERR_O, bus.FRESH_O, bus.SYNC_BUSY_O);
        else pass_cnt++;
        chk_cnt++;
        if (bus.SENSOR_WR_READY_O !== 1'b0) $display("FAIL reset_ready: got %b, required 0", bus.SENSOR_WR_READY_O);
        else pass_cnt++;
        #2 rst = 1'b0;
        tick();
        chk_cnt++;
        if (bus.SENSOR_WR_READY_O !== 1'b1) $display("FAIL post_reset_ready: got %b, required 1", bus.SENSOR_WR_READY_O);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        do_write(4'd3, 32'hDEADBEEF);
        do_sync();
        do_read(4'd3);
        chk_cnt++;
        if (bus.FRESH_O !== 12'h008) $display("FAIL basic_fresh: got %h, required 008", bus.FRESH_O);
        else pass_cnt++;
    endtask

    task automatic test_copy_forward();
        do_write(4'd5, 32'h11);
        do_sync();
        do_write(4'd2, 32'h22);
        do_sync();
        do_read(4'd5);
        do_read(4'd2);
        chk_cnt++;
        if (bus.FRESH_O !== 12'h004) $display("FAIL copy_fwd_fresh: got %h, required 004", bus.FRESH_O);
        else pass_cnt++;
    endtask

    task automatic test_same_edge();
        int lc;
        do_write(4'd2, 32'h33);
        wait_ready(lc);
        bus.SENSOR_WR_VALID_I = 1'b1;
        bus.SENSOR_WR_ID_I    = 4'd7;
        bus.SENSOR_WR_DATA_I  = 32'hAA;
        bus.SYNC_I            = 1'b1;
        bus.EN_I              = 1'b1;
        bus.SENSOR_READ_EN_I  = 1'b1;
        bus.SENSOR_ADDR_I     = 4'd2;
        tick();
        idle_inputs();
        chk_cnt++;
        if (bus.SENSOR_DATA_O !== 32'h22) $display("FAIL swap_edge_read: got %h, required 00000022", bus.SENSOR_DATA_O);
        else pass_cnt++;
        model_write(4'd7, 32'hAA);
        model_swap();
        wait_ready(lc);
        chk_cnt++;
        if (lc != N) $display("FAIL same_edge_copy_len: got %0d, required %0d", lc, N);
        else pass_cnt++;
        chk_cnt++;
        if (bus.FRESH_O !== 12'h084) $display("FAIL same_edge_fresh: got %h, required 084", bus.FRESH_O);
        else pass_cnt++;
        do_read(4'd7);
        do_read(4'd2);
    endtask

    task automatic test_pending();
        int lc;
        logic rdy [30];
        logic bsy [30];
        wait_ready(lc);
        bus.SYNC_I = 1'b1;
        tick();
        model_swap();
        for (int k = 0; k < 30; k++) begin
            rdy[k] = bus.SENSOR_WR_READY_O;
            bsy[k] = bus.SYNC_BUSY_O;
            bus.SYNC_I = (k == 3 || k == 5);
            tick();
        end
        bus.SYNC_I = 1'b0;
        model_swap();
        for (int k = 0; k < 30; k++) begin
            chk_cnt++;
            if (rdy[k] !== (k == 12 || k >= 25)) $display("FAIL pending_ready k=%0d: got %b, required %b", k, rdy[k], (k == 12 || k >= 25));
            else pass_cnt++;
            chk_cnt++;
            if (bsy[k] !== (k <= 24)) $display("FAIL pending_busy k=%0d: got %b, required %b", k, bsy[k], (k <= 24));
            else pass_cnt++;
        end
        chk_cnt++;
        if (bus.FRESH_O !== m_fresh) $display("FAIL pending_fresh: got %h, required %h", bus.FRESH_O, m_fresh);
        else pass_cnt++;
    endtask

    task automatic test_range();
        do_read(4'd15);
        do_read(4'd12);
        bus.SENSOR_READ_EN_I = 1'b1;
        bus.SENSOR_ADDR_I    = 4'd3;
        tick();
        bus.SENSOR_READ_EN_I = 1'b0;
        chk_cnt++;
        if (bus.SENSOR_DATA_VALID_O !== 1'b0) $display("FAIL en_gate_valid: got %b, required 0", bus.SENSOR_DATA_VALID_O);
        else pass_cnt++;
        do_write(4'd13, 32'h0BADF00D);
        repeat (5) tick();
        chk_cnt++;
        if (bus.WR_ERR_O !== 1'b1) $display("FAIL wr_err_sticky: got %b, required 1", bus.WR_ERR_O);
        else pass_cnt++;
        do_sync();
        for (int a = 0; a < N; a++) do_read(W'(a));
    endtask

    task automatic test_random();
        int unsigned r;
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 4)      do_write(W'($urandom_range(0, 15)), $urandom);
            else if (r <= 7) do_read(W'($urandom_range(0, 15)));
            else             do_sync();
        end
        do_sync();
        for (int a = 0; a < N; a++) do_read(W'(a));
    endtask

    task automatic test_async_reset();
        do_write(4'd4, 32'h5A5A1234);
        do_sync();
        do_read(4'd4);
        bus.SYNC_I = 1'b1;
        tick();
        bus.SYNC_I = 1'b0;
        repeat (5) tick();
        #3 rst = 1'b1;
        #1;
        chk_cnt++;
        if (bus.SENSOR_DATA_O !== '0 || bus.SENSOR_DATA_VALID_O !== 1'b0 || bus.RD_ERR_O !== 1'b0 ||
            bus.WR_ERR_O !== 1'b0 || bus.FRESH_O !== '0 || bus.SYNC_BUSY_O !== 1'b0 || bus.SENSOR_WR_READY_O !== 1'b0)
            $display("FAIL async_reset: data=%h v=%b re=%b we=%b fresh=%h busy=%b rdy=%b, required all 0",
                     bus.SENSOR_DATA_O, bus.SENSOR_DATA_VALID_O, bus.RD_ERR_O, bus.WR_ERR_O,
                     bus.FRESH_O, bus.SYNC_BUSY_O, bus.SENSOR_WR_READY_O);
        else pass_cnt++;
        #2 rst = 1'b0;
        model_reset();
        tick();
        chk_cnt++;
        if (bus.SENSOR_WR_READY_O !== 1'b1 || bus.SYNC_BUSY_O !== 1'b0)
            $display("FAIL post_async_reset: rdy=%b busy=%b, required 1/0", bus.SENSOR_WR_READY_O, bus.SYNC_BUSY_O);
        else pass_cnt++;
        for (int a = 0; a < N; a++) do_read(W'(a));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_copy_forward();
        test_same_edge();
        test_pending();
        test_range();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
